// File: rtl/lcd_fetch_pkg.sv
// Shared constants and FSM state encoding for the LCD frame fetcher.
package lcd_fetch_pkg;

    localparam int PIX_W      = 16;
    localparam int WORD_W     = 32;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_CNT_W  = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/lcd_word_fifo.sv
// Synchronous word FIFO with async reset, synchronous flush and occupancy output.
module lcd_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Status flags and qualified push/pop strobes; flush wins over both.
    always_comb begin
        empty   = (count == '0);
        full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
        dout    = mem[rp];
    end

    // Storage array, written without reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_frame_fetch.sv
// Reads a span of frame-buffer words over RAM port B and streams them as RGB565 pixels.
module lcd_frame_fetch
    import lcd_fetch_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FRAME_START,
    input  logic [ADDR_W-1:0] BASEADDR,
    input  logic [CNT_W-1:0]  WORDCOUNT,
    output logic [ADDR_W-1:0] RAM_ADDRB,
    output logic              RAM_CEB,
    output logic [3:0]        RAM_WEB,
    input  logic [WORD_W-1:0] RAM_DOB,
    output logic [PIX_W-1:0]  PIXEL,
    output logic              PIXVALID,
    input  logic              PIXREADY,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              UNDERRUN
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    remain_q;
    logic                inflight_q;
    logic                half_q;
    logic                zdone_q;

    logic [OCC_W-1:0]    occ;
    logic                fifo_empty;
    logic [WORD_W-1:0]   head;
    logic [OCC_W:0]      used;
    logic                credit;
    logic                issue;
    logic                push;
    logic                accept;
    logic                pop;
    logic                last_pix;
    logic                start_nz;
    logic                start_z;

    lcd_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .flush (FRAME_START),
        .push  (push),
        .din   (RAM_DOB),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (occ)
    );

    // Read issue, pixel unpack, status outputs and next-state selection.
    always_comb begin
        start_nz = FRAME_START && (WORDCOUNT != '0);
        start_z  = FRAME_START && (WORDCOUNT == '0);

        // The in-flight flag holds a credit so the FIFO can never overflow.
        used     = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
        credit   = (used < (OCC_W + 1)'(FIFO_DEPTH));
        issue    = (state_q == FETCH) && credit && !FRAME_START;
        push     = inflight_q && !FRAME_START;

        // Valid drops only in the abort cycle, when the FIFO is being flushed.
        PIXVALID = !fifo_empty && !FRAME_START;
        PIXEL    = '0;
        if (PIXVALID) begin
            PIXEL = half_q ? head[WORD_W-1:PIX_W] : head[PIX_W-1:0];
        end
        accept   = PIXVALID && PIXREADY;
        pop      = accept && half_q;
        last_pix = (state_q == DRAIN) && pop && (occ == OCC_W'(1)) && !inflight_q;

        RAM_ADDRB  = addr_q;
        RAM_CEB    = issue;
        RAM_WEB    = '0;
        BUSY       = (state_q != IDLE);
        FRAME_DONE = zdone_q || last_pix;
        UNDERRUN   = PIXREADY && !PIXVALID && (state_q == FETCH || state_q == DRAIN);

        state_d = state_q;
        if (FRAME_START) begin
            state_d = start_nz ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                FETCH:   if (issue && remain_q == CNT_W'(1)) state_d = DRAIN;
                DRAIN:   if (last_pix) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address/count tracking, in-flight flag, half-word select and zero-frame done.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            half_q     <= 1'b0;
            zdone_q    <= 1'b0;
        end else begin
            zdone_q    <= start_z;
            inflight_q <= issue;
            if (FRAME_START) begin
                addr_q   <= BASEADDR;
                remain_q <= WORDCOUNT;
                half_q   <= 1'b0;
            end else begin
                if (issue) begin
                    addr_q   <= addr_q + 1'b1;
                    remain_q <= remain_q - 1'b1;
                end
                if (accept) begin
                    half_q <= ~half_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_fetch.sv
// Self-checking bench for lcd_frame_fetch: RAM model, pixel/address scoreboards, corner sequences.
module tb_lcd_frame_fetch;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FRAME_START = 1'b0;
    logic [12:0] BASEADDR = '0;
    logic [13:0] WORDCOUNT = '0;
    logic [12:0] RAM_ADDRB;
    logic        RAM_CEB;
    logic [3:0]  RAM_WEB;
    logic [31:0] RAM_DOB = '0;
    logic [15:0] PIXEL;
    logic        PIXVALID;
    logic        PIXREADY = 1'b1;
    logic        BUSY;
    logic        FRAME_DONE;
    logic        UNDERRUN;

    lcd_frame_fetch #(.ADDR_W(13), .FIFO_DEPTH(DEPTH), .CNT_W(14)) dut (
        .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START), .BASEADDR(BASEADDR),
        .WORDCOUNT(WORDCOUNT), .RAM_ADDRB(RAM_ADDRB), .RAM_CEB(RAM_CEB), .RAM_WEB(RAM_WEB),
        .RAM_DOB(RAM_DOB), .PIXEL(PIXEL), .PIXVALID(PIXVALID), .PIXREADY(PIXREADY),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    logic [31:0] ram [8192];
    always @(posedge CLK) if (RAM_CEB) RAM_DOB <= ram[RAM_ADDRB];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int pix_cnt, issued, consumed, done_cnt, first_valid;
    bit nonzero;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
    logic [15:0] exp_q[$];
    logic [12:0] addr_q[$];
    int ur_q[$];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc++;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            PIXREADY = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RESET) begin
            check(RAM_WEB == 4'b0000, "ram_web", 32'(RAM_WEB), 32'd0);
            if (RAM_CEB) begin
                issued++;
                if (addr_q.size() == 0) check(1'b0, "extra_issue", 32'(RAM_ADDRB), 32'd0);
                else begin
                    logic [12:0] ea;
                    ea = addr_q.pop_front();
                    check(RAM_ADDRB == ea, "ram_addr", 32'(RAM_ADDRB), 32'(ea));
                end
            end
            if (PIXVALID && first_valid < 0) first_valid = cyc - start_cyc;
            if (UNDERRUN) ur_q.push_back(cyc - start_cyc);
            if (PIXVALID && PIXREADY) begin
                pix_cnt++;
                if (pix_cnt % 2 == 0) consumed++;
                if (exp_q.size() == 0) check(1'b0, "extra_pixel", 32'(PIXEL), 32'd0);
                else begin
                    logic [15:0] ep;
                    ep = exp_q.pop_front();
                    check(PIXEL == ep, "pixel", 32'(PIXEL), 32'(ep));
                end
            end
            check((issued - consumed) <= DEPTH, "outstanding", 32'(issued - consumed), 32'(DEPTH));
            if (FRAME_DONE) begin
                done_cnt++;
                if (nonzero)
                    check(PIXVALID && PIXREADY && exp_q.size() == 0, "done_with_last",
                          32'(exp_q.size()), 32'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the pulse.
    task automatic start_frame(input logic [12:0] b, input logic [13:0] c);
        logic [12:0] a;
        exp_q.delete(); addr_q.delete(); ur_q.delete();
        pix_cnt = 0; issued = 0; consumed = 0; done_cnt = 0; first_valid = -1;
        nonzero = (c != 0);
        for (int i = 0; i < int'(c); i++) begin
            a = b + 13'(i);
            addr_q.push_back(a);
            exp_q.push_back(ram[a][15:0]);
            exp_q.push_back(ram[a][31:16]);
        end
        BASEADDR = b; WORDCOUNT = c; FRAME_START = 1'b1; start_cyc = cyc;
        @(posedge CLK); #1;
        FRAME_START = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        check(done_cnt != 0, "done_timeout", 32'(n), 32'(budget));
    endtask

    typedef struct {
        logic [12:0] base;
        logic [13:0] cnt;
        int          mode;
        int          hold;
        int          exp_pix;
        int          exp_lat;   // -1: not checked
        bit          chk_ur;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v);
        rdy_mode = (v.hold > 0) ? 2 : v.mode;
        start_frame(v.base, v.cnt);
        if (v.hold > 0) begin
            repeat (v.hold) @(posedge CLK);
            #1;
            check(issued == DEPTH, "hold_issued", 32'(issued), 32'(DEPTH));
            check(pix_cnt == 0, "hold_no_pixel", 32'(pix_cnt), 32'd0);
            rdy_mode = v.mode;
        end
        wait_done(4000);
        repeat (2) @(posedge CLK);
        #1;
        check(pix_cnt == v.exp_pix, "pix_count", 32'(pix_cnt), 32'(v.exp_pix));
        check(done_cnt == 1, "done_count", 32'(done_cnt), 32'd1);
        check(exp_q.size() == 0 && addr_q.size() == 0, "queues_empty",
              32'(exp_q.size() + addr_q.size()), 32'd0);
        check(BUSY == 1'b0, "idle_after", 32'(BUSY), 32'd0);
        if (v.exp_lat >= 0) check(first_valid == v.exp_lat, "latency", 32'(first_valid), 32'(v.exp_lat));
        if (v.chk_ur)
            check(ur_q.size() == 2 && ur_q[0] == 1 && ur_q[1] == 2, "underrun_cycles",
                  32'(ur_q.size()), 32'd2);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = {16'(i) ^ 16'hC3C3, 16'(i * 3 + 1)};
        ram[13'h0010] = 32'hAAAA5555;
        ram[13'h0011] = 32'h12345678;

        vecs[0] = '{13'h0010, 14'd2,  0, 0,  4,  3, 1'b1};
        vecs[1] = '{13'h1FFE, 14'd4,  0, 0,  8,  3, 1'b1};
        vecs[2] = '{13'h0200, 14'd16, 1, 20, 32, -1, 1'b0};
        vecs[3] = '{13'h0300, 14'd5,  1, 0,  10, -1, 1'b0};

        #1;
        check({RAM_ADDRB, RAM_CEB, RAM_WEB, PIXEL, PIXVALID, BUSY, FRAME_DONE, UNDERRUN} == '0,
              "reset_state", 32'({RAM_ADDRB, RAM_CEB, PIXVALID, BUSY, FRAME_DONE}), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Basic frame: fixed expected pixel order from the known RAM words.
        check(ram[13'h0010][15:0] == 16'h5555 && ram[13'h0011][31:16] == 16'h1234, "basic_words",
              ram[13'h0010], 32'hAAAA5555);
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Abort after three pixels; restart on a one-word frame at 0x0100.
        rdy_mode = 0;
        start_frame(13'h0020, 14'd4);
        begin
            int n = 0;
            while (pix_cnt < 3 && n < 50) begin
                @(posedge CLK); #1;
                n++;
            end
            check(pix_cnt == 3, "abort_wait", 32'(pix_cnt), 32'd3);
        end
        start_frame(13'h0100, 14'd1);
        wait_done(200);
        repeat (4) @(posedge CLK);
        #1;
        check(pix_cnt == 2, "abort_pix_count", 32'(pix_cnt), 32'd2);
        check(done_cnt == 1, "abort_done_count", 32'(done_cnt), 32'd1);

        // Zero-length frame.
        start_frame(13'h0040, 14'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            check(RAM_CEB == 1'b0 && BUSY == 1'b0, "zero_idle", 32'({RAM_CEB, BUSY}), 32'd0);
            check(FRAME_DONE == (k == 1), "zero_done", 32'(FRAME_DONE), 32'(k == 1));
            @(posedge CLK); #1;
        end

        // Asynchronous reset in the middle of a fetch.
        rdy_mode = 2;
        start_frame(13'h0400, 14'd16);
        repeat (3) @(posedge CLK);
        #1;
        check(BUSY == 1'b1, "busy_fetch", 32'(BUSY), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check({RAM_ADDRB, RAM_CEB, PIXEL, PIXVALID, BUSY, FRAME_DONE, UNDERRUN} == '0,
              "reset_midframe", 32'({RAM_ADDRB, RAM_CEB, PIXVALID, BUSY}), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        rdy_mode = 0;
        @(negedge CLK);
        check(BUSY == 1'b0 && RAM_CEB == 1'b0 && PIXVALID == 1'b0, "idle_after_reset",
              32'({BUSY, RAM_CEB, PIXVALID}), 32'd0);
        @(posedge CLK); #1;

        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lcd_frame_fetch.md
Name: lcd_frame_fetch

Overview:
Downstream consumer of port B of the 8192x32 frame-buffer dual-port RAM. It reads a programmed span of 32-bit words, buffers them in a small word FIFO, and unpacks each word into two RGB565 pixels. The pixels go out on a valid/ready stream to the LCD timing/serialiser stage. Port A stays with the bus-side writer; this block only reads.

Parameters:
ADDR_W, 13, RAM word-address width (8192 words)
FIFO_DEPTH, 4, word FIFO entries; power of two, minimum 2
CNT_W, 14, width of word-count input (allows a 8192-word span)

Ports:
CLK  in  1  single clock; same clock drives RAM CLKB
RESET  in  1  asynchronous, active-high reset
FRAME_START  in  1  single-cycle pulse; begins a frame fetch (aborts any frame in progress)
BASEADDR  in  ADDR_W  first word address, sampled on FRAME_START
WORDCOUNT  in  CNT_W  words per frame, sampled on FRAME_START
RAM_ADDRB  out  ADDR_W  port-B address
RAM_CEB  out  1  port-B chip enable (read strobe)
RAM_WEB  out  4  port-B byte write enables, constant 4'b0000
RAM_DOB  in  32  port-B read data, valid one cycle after RAM_CEB
PIXEL  out  16  RGB565 pixel
PIXVALID  out  1  PIXEL is valid
PIXREADY  in  1  consumer accepts PIXEL when PIXVALID&PIXREADY
BUSY  out  1  frame in progress (FETCH or DRAIN)
FRAME_DONE  out  1  one-cycle pulse when the last pixel of a frame is accepted
UNDERRUN  out  1  one-cycle pulse: PIXREADY high, PIXVALID low, state FETCH or DRAIN

Behaviour:
- Reset values: RAM_ADDRB=0, RAM_CEB=0, RAM_WEB=0, PIXEL=0, PIXVALID=0, BUSY=0, FRAME_DONE=0, UNDERRUN=0. FIFO is empty and state is IDLE.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE -> FETCH on FRAME_START with WORDCOUNT!=0.
- FRAME_START with WORDCOUNT==0: stay IDLE and pulse FRAME_DONE on the next cycle.
- FETCH -> DRAIN when the last word read is issued.
- DRAIN -> IDLE when the last pixel is accepted; FRAME_DONE pulses in that same cycle.
- FRAME_START in FETCH or DRAIN aborts the frame: flush the FIFO, drop the half-word select, discard in-flight read data, reload BASEADDR/WORDCOUNT, enter FETCH. No FRAME_DONE for the aborted frame.
- Read issue: RAM_CEB=1 in a FETCH cycle only when (FIFO occupancy + reads in flight) < FIFO_DEPTH (credit check). RAM_ADDRB increments after each issue and wraps modulo 2^ADDR_W (8191 -> 0). A remaining-word counter decrements per issue.
- Read latency: RAM_DOB captured into the FIFO on the edge following the cycle after RAM_CEB. At most one read is in flight, registered as a flag, so the credit includes it.
- Minimum latency: FRAME_START at cycle 0 -> RAM_CEB=1 at cycle 1 with ADDR=BASEADDR -> data written to FIFO end of cycle 2 -> PIXVALID=1 in cycle 3.
- Unpack order: PIXEL = word[15:0] first, then word[31:16].
  - The FIFO pops on acceptance of the upper half-word.
  - PIXEL/PIXVALID come combinationally from the FIFO head and the half select, with no extra register.
  - PIXVALID may not drop without acceptance, except on abort or reset.
- Throughput: sustained 1 pixel/cycle with PIXREADY=1 once the FIFO holds at least 1 word (2 cycles per word against 1 read per cycle).
- Simultaneous FIFO push and pop in one cycle are allowed; occupancy is unchanged.
- BUSY=1 in FETCH and DRAIN.
- UNDERRUN is informational only; it does not change state.
- Asynchronous RESET mid-frame returns everything to reset values immediately. In-flight RAM data is ignored.

Decomposition:
- Package lcd_fetch_pkg: state encoding (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2), PIX_W=16, WORD_W=32, and default ADDR_W/CNT_W constants.
- One natural sub-module, lcd_word_fifo: synchronous FIFO with parameterised depth, async active-high reset and a synchronous flush input. It exports occupancy for the credit check.

Test Plan:
- Basic: BASEADDR=0x0010, WORDCOUNT=2, RAM words 0xAAAA5555 and 0x12345678, PIXREADY=1 -> PIXEL sequence 0x5555, 0xAAAA, 0x5678, 0x1234. First PIXVALID 3 cycles after FRAME_START. FRAME_DONE with the 4th pixel. RAM_WEB always 0.
- Backpressure: WORDCOUNT=16, PIXREADY held low 20 cycles, then toggled randomly -> never more than FIFO_DEPTH words outstanding (RAM_CEB stops). All 32 pixels arrive in order with none lost or duplicated.
- Wrap: BASEADDR=0x1FFE, WORDCOUNT=4 -> RAM_ADDRB issues 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Abort: FRAME_START again after 3 pixels with BASEADDR=0x0100, WORDCOUNT=1 -> no stale pixel from the first frame. The next two pixels are from word 0x0100, then a single FRAME_DONE.
- Zero count: WORDCOUNT=0 -> no RAM_CEB, BUSY stays 0, FRAME_DONE one cycle after FRAME_START.
- Reset and underrun: assert RESET mid-FETCH -> all outputs 0 at once and IDLE after release. With PIXREADY=1 at frame start, UNDERRUN pulses in cycles 1 and 2 only.
